// File: rtl/dmem_wait.sv
// Data memory with a fixed access latency, byte-lane writes and a small MMIO window
// (TOHOST / CYCLES). When LAT=0 the array behaves as a single-cycle combinational-read memory.
module dmem_wait #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LAT       = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [31:0]           daddr,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DATA_W-1:0]     dwdata,
    output logic [DATA_W-1:0]     drdata,
    output logic                  ack,
    output logic                  err,
    output logic                  halt,
    output logic [DATA_W-1:0]     tohost
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam int unsigned OFS      = $clog2(NB);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [2:0]  CNT_INIT = 3'((LAT > 0) ? LAT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [NB-1:0]       we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   tohost_q, tohost_d;
    logic [DATA_W-1:0]   cycles_q;
    logic                halt_q, halt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                fire_c;
    logic [31:0]         a_addr_c;
    logic [NB-1:0]       a_we_c;
    logic [DATA_W-1:0]   a_wdata_c;
    logic [31:0]         mmio_off_c;
    logic [AW-1:0]       word_idx_c;
    logic [DATA_W-1:0]   rdata_c;
    logic                acc_err_c;
    logic                mem_wr_c;
    logic                host_wr_c;
    logic                mem_commit_c;

    // The access being completed: live inputs when LAT=0, otherwise the latched request.
    always_comb begin
        if (LAT == 0) begin
            a_addr_c  = daddr;
            a_we_c    = we;
            a_wdata_c = dwdata;
            fire_c    = req;
        end else begin
            a_addr_c  = addr_q;
            a_we_c    = we_q;
            a_wdata_c = wdata_q;
            fire_c    = (state_q == WAIT) && (cnt_q == 3'd0);
        end
    end

    // Address decode; misalignment first, then MMIO window, then array range.
    always_comb begin
        mmio_off_c = a_addr_c - MMIO_BASE;
        word_idx_c = a_addr_c[AW+OFS-1:OFS];
        rdata_c    = '0;
        acc_err_c  = 1'b0;
        mem_wr_c   = 1'b0;
        host_wr_c  = 1'b0;
        if (a_addr_c[OFS-1:0] != '0) begin
            acc_err_c = 1'b1;
        end else if (mmio_off_c < 32'd256) begin
            if (mmio_off_c == 32'd0) begin
                rdata_c = tohost_q;
                if ((|a_we_c) && !(&a_we_c)) acc_err_c = 1'b1;
                else                         host_wr_c = &a_we_c;
            end else if (mmio_off_c == 32'(NB)) begin
                rdata_c = cycles_q;
            end else begin
                acc_err_c = 1'b1;
            end
        end else if (a_addr_c[31:AW+OFS] != '0) begin
            acc_err_c = 1'b1;
        end else begin
            rdata_c  = mem_q[word_idx_c];
            mem_wr_c = |a_we_c;
        end
    end

    // A synchronous reset in the completion cycle cancels the ack and any commit.
    assign ack          = fire_c && !reset;
    assign err          = ack && acc_err_c;
    assign drdata       = (ack && !acc_err_c) ? rdata_c : '0;
    assign mem_commit_c = ack && mem_wr_c;
    assign halt         = halt_q;
    assign tohost       = tohost_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        halt_d   = halt_q;
        tohost_d = tohost_q;
        case (state_q)
            IDLE: begin
                if ((LAT != 0) && req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = daddr;
                    we_d    = we;
                    wdata_d = dwdata;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) cnt_d   = cnt_q - 3'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (ack && host_wr_c) begin
            tohost_d = a_wdata_c;
            halt_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 32'd0;
            we_q     <= '0;
            wdata_q  <= '0;
            halt_q   <= 1'b0;
            tohost_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            halt_q   <= halt_d;
            tohost_q <= tohost_d;
            cycles_q <= cycles_q + DATA_W'(1);
        end
    end

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_commit_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (a_we_c[i]) mem_q[word_idx_c][8*i +: 8] <= a_wdata_c[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_wait.md
DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; multiple of 8, 32 or 64.
REQ-002 Parameter DEPTH, default 1024, array depth in words; power of two.
REQ-003 Parameter LAT, default 2, access latency in cycles, 0..7.
REQ-004 Parameter MMIO_BASE, default 32'hFFFF_0000, byte address of the MMIO window.
REQ-005 Derived NB = DATA_W/8 byte lanes; OFS = log2(NB); word index = daddr[log2(DEPTH)+OFS-1:OFS].
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  1  access request; daddr/we/dwdata valid while high.
REQ-009 daddr  input  32  byte address.
REQ-010 we  input  NB  per-byte write enable; all zero means read.
REQ-011 dwdata  input  DATA_W  write data, lane i = bits [8i+7:8i].
REQ-012 drdata  output  DATA_W  read data, valid only while ack is high.
REQ-013 ack  output  1  one-cycle completion strobe.
REQ-014 err  output  1  error qualifier, valid only while ack is high.
REQ-015 halt  output  1  sticky, set by a TOHOST write.
REQ-016 tohost  output  DATA_W  last value written to TOHOST.

Function
REQ-017 States IDLE and WAIT; LAT=0 uses IDLE only.
REQ-018 LAT=0: ack = req combinationally; read data asynchronous from daddr; write commits at the edge ending the req cycle.
REQ-019 LAT>=1, IDLE with req: latch daddr/we/dwdata, cnt <= LAT-1, go to WAIT; ack stays 0.
REQ-020 WAIT with cnt!=0: cnt decrements by 1. WAIT with cnt==0: ack=1, drdata/err computed from the latched request, go to IDLE. Result: ack is high exactly LAT cycles after the req acceptance cycle.
REQ-021 A write commits at the edge ending the ack cycle; only lanes with we[i]=1 change.
REQ-022 req, daddr, we and dwdata are ignored while in WAIT; a req drop mid-WAIT does not cancel the latched access.
REQ-023 A new request is accepted no earlier than the cycle after ack; back-to-back accesses therefore complete every LAT+1 cycles.
REQ-024 Misaligned access (daddr[OFS-1:0]!=0): err=1, drdata=0, no state change.
REQ-025 Out-of-range access (non-MMIO, daddr>>OFS >= DEPTH): err=1, drdata=0, no write.
REQ-026 TOHOST at MMIO_BASE: read returns tohost; a write with we all-ones sets tohost<=dwdata and halt<=1; a partial-we write sets err=1 and changes nothing.
REQ-027 CYCLES at MMIO_BASE+NB: read returns a free-running DATA_W counter, incremented every cycle and wrapping to 0; writes are ignored with err=0.
REQ-028 Any other address in [MMIO_BASE, MMIO_BASE+256) gives err=1 and drdata=0.
REQ-029 MMIO decode takes precedence over the array range check.
REQ-030 A TOHOST write while halt=1 updates tohost; halt stays 1.

Reset
REQ-031 On reset: state=IDLE, cnt=0, ack=0, err=0, halt=0, tohost=0, CYCLES=0.
REQ-032 drdata=0 whenever ack=0.
REQ-033 Reset during WAIT aborts the access: no write, no ack.
REQ-034 Reset does not alter array contents.

Verification
REQ-035 LAT=2: write 32'hDEADBEEF to 0x10 with we=4'hF, then read 0x10 -> ack exactly 2 cycles after each acceptance, drdata=32'hDEADBEEF, err=0.
REQ-036 Byte lanes: preload 0x20 with 32'h11223344, write 32'hAABBCCDD with we=4'b0101, read back -> 32'h11BB33DD.
REQ-037 Errors: read 0x22 -> err=1, drdata=0; write to DEPTH*4 -> err=1, and word 0 is unchanged.
REQ-038 MMIO: write 32'h1 to MMIO_BASE -> halt=1 and tohost=1 on the next cycle; two CYCLES reads N cycles apart differ by N.
REQ-039 Reset in the second WAIT cycle of a write to 0x30 -> no ack, and word 0x30 keeps its prior value.
REQ-040 LAT=0, DATA_W=64: write 64'h0123456789ABCDEF to 0x8 with we=8'hFF; a read in the same cycle returns the old value, and a read in the next cycle returns the new value with ack=req.
